imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CKSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int DEPTH_DEF = 1000;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int LANES     = WORD_W / BYTE_W;
    localparam int LANE_W    = $clog2(LANES);
    localparam int LEN_W     = 2 * BYTE_W;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CKSUM,
`endif
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Collects bytes LSB-first into a 32-bit instruction word.
// word_next shows the word as it will look once din is taken.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    output logic [WORD_W-1:0] word_next,
    output logic              last
);

    logic [LANE_W-1:0] cnt;
    logic [WORD_W-1:0] asm_q;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (push) begin
            cnt   <= cnt + 1'b1;
            asm_q <= word_next;
        end
    end

    always_comb begin
        word_next = asm_q;
        word_next[cnt*BYTE_W +: BYTE_W] = din;
    end

    assign last = (cnt == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, holding the
// core until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST = CKSUM;
    logic [BYTE_W-1:0] cks_q;
`else
    localparam state_t POST = DONE;
`endif

    state_t             state, nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_full;
    logic [LEN_W-1:0]   idx;
    logic               take, push, pk_last;
    logic [WORD_W-1:0]  pk_word;

    assign take     = in_valid && in_ready;
    assign push     = take && (state == DATA);
    assign len_full = {in_data, len_q[BYTE_W-1:0]};

    imem_word_packer u_packer (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .push      (push),
        .din       (in_data),
        .word_next (pk_word),
        .last      (pk_last)
    );

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_hold  = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            LEN0: begin
                in_ready = 1'b1;
                if (in_valid) nxt = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_full == '0)
                        nxt = POST;
                    else if ({16'd0, len_full} > DEPTH_U)
                        nxt = ERR;
                    else
                        nxt = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid && pk_last) nxt = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                nxt    = (idx < len_q - 1'b1) ? DATA : POST;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (in_valid) nxt = (in_data == cks_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            ERR: begin
                load_err = 1'b1;
            end
            default: nxt = LEN0;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state     <= LEN0;
            len_q     <= '0;
            idx       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks_q     <= '0;
`endif
        end else begin
            state <= nxt;
            if (take && state == LEN0) len_q[BYTE_W-1:0] <= in_data;
            if (take && state == LEN1) len_q[LEN_W-1:BYTE_W] <= in_data;
            // Latch address/data as the 4th byte lands so WRITE sees them.
            if (push && pk_last) begin
                mem_addr  <= ADDR_W'(idx);
                mem_wdata <= pk_word;
            end
            if (state == WRITE && nxt == DATA) idx <= idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (push) cks_q <= cks_q ^ in_data;
`endif
        end
    end

endmodule
